mac_window_collector: RTL and testbench
=======================================

Name: mac_window_collector

Overview:
- Sits directly downstream of the attribute/coefficient MAC stage and consumes its 20-bit acc result stream.
- Groups consecutive valid acc samples into fixed windows of WIN samples.
- Per window, computes the maximum acc and the count of samples at or above a programmable threshold.
- Queues one record per window in a small FIFO, read out by the decision logic over a valid/ready handshake.

Parameters:
- ACC_W, 20, width of the acc input and of all acc-derived fields.
- WIN, 8, samples per window (2..255).
- DEPTH, 4, FIFO depth in records (power of two, at least 2).
- CNT_W, 8, width of the hit-count field (must hold WIN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- acc_in  input  ACC_W  MAC result, unsigned.
- acc_valid  input  1  acc_in is a sample this cycle (no backpressure upstream).
- thr_in  input  ACC_W  threshold value.
- thr_load  input  1  latch thr_in into the shadow threshold.
- out_valid  output  1  FIFO head record available.
- out_ready  input  1  consumer accepts head record.
- out_max  output  ACC_W  window maximum.
- out_hits  output  CNT_W  samples with acc_in >= threshold in the window.
- out_sum  output  ACC_W  saturating window sum (see Optional Feature).
- overflow  output  1  sticky: a window record was dropped.
- fill  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, takes effect immediately):
  - out_valid=0, out_max=0, out_hits=0, out_sum=0, overflow=0, fill=0.
  - Window counter=0, active and shadow thresholds=0, FSM=IDLE.
- FSM states:
  - IDLE: counter=0. On acc_valid, first sample initialises running max=acc_in and hits=(acc_in>=thr_active); go to COLLECT. If WIN would be 1 it is unsupported (WIN>=2 enforced).
  - COLLECT: each acc_valid updates max=max(max,acc_in), hits+=(acc_in>=thr_active), counter+=1.
    - Gaps with acc_valid=0 hold all state.
    - The sample that makes counter reach WIN is the closing sample: its contribution is included, the record is pushed on that same edge, and the FSM returns to IDLE.
- Latency: closing sample at edge N gives out_valid=1 after edge N (visible in the cycle following the closing sample) if the FIFO was empty.
- Threshold:
  - thr_load latches thr_in into shadow.
  - shadow is copied to active only on the IDLE->COLLECT transition.
  - A load mid-window therefore affects the next window only.
  - thr_load coinciding with a window's first sample: the new value applies to that window (shadow bypass).
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when full and no pop in the same cycle: record dropped, overflow set to 1, held until rst.
  - Push and pop in the same cycle while full: both succeed, fill unchanged.
  - Push and pop in the same cycle while empty: the record is written, out_valid=1 next cycle (no bypass).
  - out_max, out_hits and out_sum show the head record and hold stable while out_valid=1 and out_ready=0.
- Widths:
  - Comparisons are unsigned.
  - hits never exceeds WIN.
  - fill ranges over 0..DEPTH.
- Reset mid-window discards the partial window and all queued records.

Optional Feature:
- Macro: MAC_WINDOW_SUM_EN.
- Defined:
  - Each window also accumulates a running sum of acc_in, saturating at 2^ACC_W-1.
  - The sum is stored in the record and driven on out_sum.
- Undefined:
  - No sum logic or storage.
  - out_sum is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Basic window, WIN=8, thr=400. Feed 490,470,300,500,100,410,0,399 (gaps allowed).
  - One record: out_max=500, out_hits=4, out_valid high one cycle after the 8th sample.
  - With MAC_WINDOW_SUM_EN: out_sum=2669.
- Mid-window threshold load:
  - Window 1 starts with thr=400.
  - After 3 samples, load thr=100.
  - Window 1 still counts against 400; window 2 counts against 100.
- Backpressure and overflow:
  - Hold out_ready=0 and feed 5 full windows with DEPTH=4.
  - Expect fill=4 and overflow=1 after window 5.
  - Release out_ready: records 1-4 pop in order and head fields stay stable while stalled.
- Full with simultaneous pop:
  - With fill=4 and out_ready=1 on the closing-sample cycle, the push succeeds.
  - fill stays 4 and overflow stays 0.
- Saturation (MAC_WINDOW_SUM_EN):
  - 8 samples of 1048575: out_sum=1048575, out_max=1048575, out_hits=8 with thr=0.
- Reset mid-operation:
  - Assert rst after 5 samples with 2 records queued.
  - All outputs read 0 immediately.
  - The next 8 samples produce a fresh, correct record.

Source files
------------

// File: rtl/mac_window_collector.sv
// mac_window_collector: groups valid MAC acc samples into windows of WIN
// samples and computes the window maximum and the count of samples at or
// above a threshold. One record per window is queued in a DEPTH-entry FIFO
// and read out over a valid/ready handshake.
// Optional feature macro: MAC_WINDOW_SUM_EN adds a saturating window sum.
// Without it, out_sum is tied to 0.
//
// state   | meaning
// S_IDLE  | no window open; next valid sample starts one
// S_COLLECT | window open; counting samples until WIN reached
module mac_window_collector #(
  parameter int ACC_W = 20,
  parameter int WIN   = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACC_W-1:0]         acc_in,
  input  logic                     acc_valid,
  input  logic [ACC_W-1:0]         thr_in,
  input  logic                     thr_load,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_max,
  output logic [CNT_W-1:0]         out_hits,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] LAST = 8'(WIN - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t r_state, w_state_nxt;
  logic   w_first, w_close;

  logic [7:0]       r_cnt;
  logic [ACC_W-1:0] r_max, r_thr_shadow, r_thr_active;
  logic [CNT_W-1:0] r_hits;

  logic [ACC_W-1:0] w_thr_new, w_thr_use, w_max_nxt;
  logic [CNT_W-1:0] w_hits_nxt;
  logic             w_hit;

  logic [ACC_W-1:0] r_mem_max  [DEPTH];
  logic [CNT_W-1:0] r_mem_hits [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             r_overflow;
  logic             w_pop, w_full, w_wr_en;

`ifdef MAC_WINDOW_SUM_EN
  logic [ACC_W-1:0] r_sum;
  logic [ACC_W-1:0] r_mem_sum [DEPTH];
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_sum_nxt;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: open a window on the first sample, close it on sample WIN.
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (acc_valid) begin
          w_first     = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (acc_valid && (r_cnt == LAST)) begin
          w_close     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A load on the opening sample bypasses the shadow so it applies immediately.
  assign w_thr_new  = thr_load ? thr_in : r_thr_shadow;
  assign w_thr_use  = w_first ? w_thr_new : r_thr_active;
  assign w_hit      = (acc_in >= w_thr_use);
  assign w_max_nxt  = (w_first || (acc_in > r_max)) ? acc_in : r_max;
  assign w_hits_nxt = (w_first ? '0 : r_hits) + {{(CNT_W-1){1'b0}}, w_hit};

`ifdef MAC_WINDOW_SUM_EN
  assign w_sum_wide = {1'b0, (w_first ? '0 : r_sum)} + {1'b0, acc_in};
  assign w_sum_nxt  = w_sum_wide[ACC_W] ? '1 : w_sum_wide[ACC_W-1:0];

  // Running saturating sum of the open window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_sum <= '0;
    else if (acc_valid) r_sum <= w_sum_nxt;
  end
`endif

  // Window accumulators, sample counter and threshold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_max        <= '0;
      r_hits       <= '0;
      r_thr_shadow <= '0;
      r_thr_active <= '0;
    end else begin
      if (thr_load) r_thr_shadow <= thr_in;
      if (w_first)  r_thr_active <= w_thr_new;
      if (acc_valid) begin
        r_max  <= w_max_nxt;
        r_hits <= w_hits_nxt;
        if (w_close)      r_cnt <= '0;
        else if (w_first) r_cnt <= 8'd1;
        else              r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign w_pop   = out_valid && out_ready;
  assign w_full  = (r_fill == FULL);
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr_en = w_close && (!w_full || w_pop);

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_fill <= r_fill + ONE;
      else if (!w_wr_en && w_pop) r_fill <= r_fill - ONE;
      if (w_close && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Record storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_max[r_wr_ptr]  <= w_max_nxt;
      r_mem_hits[r_wr_ptr] <= w_hits_nxt;
`ifdef MAC_WINDOW_SUM_EN
      r_mem_sum[r_wr_ptr]  <= w_sum_nxt;
`endif
    end
  end

  assign out_valid = (r_fill != '0);
  assign fill      = r_fill;
  assign overflow  = r_overflow;
  assign out_max   = out_valid ? r_mem_max[r_rd_ptr]  : '0;
  assign out_hits  = out_valid ? r_mem_hits[r_rd_ptr] : '0;
`ifdef MAC_WINDOW_SUM_EN
  assign out_sum   = out_valid ? r_mem_sum[r_rd_ptr]  : '0;
`else
  assign out_sum   = '0;
`endif

endmodule

// File: tb/tb_mac_window_collector.sv
// Testbench for mac_window_collector: vector table for the basic window,
// hand sequences for threshold, backpressure, full+pop, saturation and
// reset, then randomized traffic against a queue-based reference model.
module tb_mac_window_collector;

  localparam int ACC_W = 20;
  localparam int WIN   = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [ACC_W-1:0] acc_in = '0;
  logic             acc_valid = 1'b0;
  logic [ACC_W-1:0] thr_in = '0;
  logic             thr_load = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_max;
  logic [CNT_W-1:0] out_hits;
  logic [ACC_W-1:0] out_sum;
  logic             overflow;
  logic [2:0]       fill;

  mac_window_collector #(.ACC_W(ACC_W), .WIN(WIN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid),
    .thr_in(thr_in), .thr_load(thr_load), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_hits(out_hits),
    .out_sum(out_sum), .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a window is a list of samples judged against the
  // threshold in force when it opened; finished windows go into a queue.
  typedef struct {
    longint mx;
    longint hits;
    longint sum;
  } rec_t;

  rec_t   q[$];
  longint win_samples[$];
  longint win_thr;
  longint m_shadow;
  logic   m_ovf;

  typedef struct {
    logic             v;
    logic [ACC_W-1:0] acc;
    logic             rdy;
    logic             ev;
    logic [ACC_W-1:0] emax;
    logic [CNT_W-1:0] ehits;
    logic [2:0]       efill;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sum_seen(input longint s);
`ifdef MAC_WINDOW_SUM_EN
    return s;
`else
    return 0;
`endif
  endfunction

  function automatic rec_t close_window();
    rec_t r;
    longint s;
    r.mx = 0; r.hits = 0; s = 0;
    foreach (win_samples[i]) begin
      if (win_samples[i] > r.mx) r.mx = win_samples[i];
      if (win_samples[i] >= win_thr) r.hits++;
      s += win_samples[i];
    end
    r.sum = (s > MAXV) ? MAXV : s;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    win_samples.delete();
    win_thr  = 0;
    m_shadow = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("fill", {61'd0, fill}, 64'(q.size()));
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    if (q.size() != 0) begin
      chk("out_max", {44'd0, out_max}, q[0].mx);
      chk("out_hits", {56'd0, out_hits}, q[0].hits);
      chk("out_sum", {44'd0, out_sum}, sum_seen(q[0].sum));
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model and DUT.
  task automatic step(input logic v, input logic [ACC_W-1:0] a, input logic ld,
                      input logic [ACC_W-1:0] t, input logic rdy);
    logic pop;
    logic push;
    rec_t r;
    check_outputs();
    acc_valid = v; acc_in = a; thr_load = ld; thr_in = t; out_ready = rdy;
    pop  = (q.size() != 0) && rdy;
    push = 1'b0;
    if (v) begin
      if (win_samples.size() == 0) win_thr = ld ? longint'(t) : m_shadow;
      win_samples.push_back(longint'(a));
      if (win_samples.size() == WIN) begin
        r = close_window();
        push = 1'b1;
        win_samples.delete();
      end
    end
    if (ld) m_shadow = longint'(t);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    acc_valid = 1'b0;
    thr_load  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fill", {61'd0, fill}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_out_max", {44'd0, out_max}, 64'd0);
    chk("rst_out_hits", {56'd0, out_hits}, 64'd0);
    chk("rst_out_sum", {44'd0, out_sum}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic feed_window(input logic rdy);
    for (int i = 0; i < WIN; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b0, '0, rdy);
      step(1'b1, ACC_W'($urandom_range(0, 1000)), 1'b0, '0, rdy);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 20'd490, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[1]  = '{1'b1, 20'd470, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[2]  = '{1'b0, 20'd0,   1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[3]  = '{1'b1, 20'd300, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[4]  = '{1'b1, 20'd500, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[5]  = '{1'b1, 20'd100, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[6]  = '{1'b0, 20'd0,   1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[7]  = '{1'b1, 20'd410, 1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[8]  = '{1'b1, 20'd0,   1'b0, 1'b0, 20'd0,   8'd0, 3'd0};
    tbl[9]  = '{1'b1, 20'd399, 1'b0, 1'b1, 20'd500, 8'd4, 3'd1};
    tbl[10] = '{1'b0, 20'd0,   1'b0, 1'b1, 20'd500, 8'd4, 3'd1};
    tbl[11] = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   8'd0, 3'd0};

    model_reset();
    @(negedge clk);
    do_reset();

    // Basic window, thr=400.
    step(1'b0, '0, 1'b1, 20'd400, 1'b0);
    foreach (tbl[i]) begin
      if (i == 10) chk("basic_sum", {44'd0, out_sum}, sum_seen(2669));
      step(tbl[i].v, tbl[i].acc, 1'b0, '0, tbl[i].rdy);
      chk("basic_valid", {63'd0, out_valid}, {63'd0, tbl[i].ev});
      chk("basic_fill", {61'd0, fill}, {61'd0, tbl[i].efill});
      if (tbl[i].ev) begin
        chk("basic_max", {44'd0, out_max}, {44'd0, tbl[i].emax});
        chk("basic_hits", {56'd0, out_hits}, {56'd0, tbl[i].ehits});
      end
    end

    // Mid-window threshold load affects only the next window.
    do_reset();
    step(1'b0, '0, 1'b1, 20'd400, 1'b0);
    step(1'b1, 20'd500, 1'b0, '0, 1'b0);
    step(1'b1, 20'd50,  1'b0, '0, 1'b0);
    step(1'b1, 20'd450, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 20'd100, 1'b0);
    step(1'b1, 20'd150, 1'b0, '0, 1'b0);
    step(1'b1, 20'd200, 1'b0, '0, 1'b0);
    step(1'b1, 20'd420, 1'b0, '0, 1'b0);
    step(1'b1, 20'd30,  1'b0, '0, 1'b0);
    step(1'b1, 20'd99,  1'b0, '0, 1'b0);
    step(1'b1, 20'd150, 1'b0, '0, 1'b0);
    step(1'b1, 20'd90,  1'b0, '0, 1'b0);
    step(1'b1, 20'd100, 1'b0, '0, 1'b0);
    step(1'b1, 20'd101, 1'b0, '0, 1'b0);
    step(1'b1, 20'd5,   1'b0, '0, 1'b0);
    step(1'b1, 20'd600, 1'b0, '0, 1'b0);
    step(1'b1, 20'd99,  1'b0, '0, 1'b0);
    step(1'b1, 20'd100, 1'b0, '0, 1'b0);
    chk("midthr_w1_hits", {56'd0, out_hits}, 64'd3);
    chk("midthr_w1_max", {44'd0, out_max}, 64'd500);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("midthr_w2_hits", {56'd0, out_hits}, 64'd5);
    chk("midthr_w2_max", {44'd0, out_max}, 64'd600);
    step(1'b0, '0, 1'b0, '0, 1'b1);

    // Backpressure: five windows into a four-deep FIFO.
    do_reset();
    step(1'b0, '0, 1'b1, 20'd500, 1'b0);
    for (int w = 0; w < 5; w++) feed_window(1'b0);
    chk("bp_fill", {61'd0, fill}, 64'd4);
    chk("bp_overflow", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("bp_drained", {61'd0, fill}, 64'd0);

    // Full FIFO with a pop on the closing-sample cycle.
    do_reset();
    for (int w = 0; w < 4; w++) feed_window(1'b0);
    for (int i = 0; i < WIN - 1; i++) step(1'b1, ACC_W'(i * 7), 1'b0, '0, 1'b0);
    step(1'b1, 20'd777, 1'b0, '0, 1'b1);
    chk("fullpop_fill", {61'd0, fill}, 64'd4);
    chk("fullpop_overflow", {63'd0, overflow}, 64'd0);

    // Saturation with thr=0.
    do_reset();
    for (int i = 0; i < WIN; i++) step(1'b1, 20'hFFFFF, 1'b0, '0, 1'b0);
    chk("sat_max", {44'd0, out_max}, 64'd1048575);
    chk("sat_hits", {56'd0, out_hits}, 64'd8);
    chk("sat_sum", {44'd0, out_sum}, sum_seen(1048575));

    // Reset mid-window with two records queued.
    do_reset();
    for (int w = 0; w < 2; w++) feed_window(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 20'd900, 1'b0, '0, 1'b0);
    chk("prerst_fill", {61'd0, fill}, 64'd2);
    do_reset();
    step(1'b0, '0, 1'b1, 20'd35, 1'b0);
    for (int i = 1; i <= WIN; i++) step(1'b1, ACC_W'(i * 10), 1'b0, '0, 1'b0);
    chk("postrst_max", {44'd0, out_max}, 64'd80);
    chk("postrst_hits", {56'd0, out_hits}, 64'd5);
    chk("postrst_sum", {44'd0, out_sum}, sum_seen(360));
    chk("postrst_fill", {61'd0, fill}, 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic             v, ld, rdy;
      logic [ACC_W-1:0] a, t;
      v   = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : ACC_W'($urandom_range(0, 1000));
      ld  = ($urandom_range(0, 11) == 0);
      t   = ACC_W'($urandom_range(0, 1000));
      rdy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step(v, a, ld, t, rdy);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
